// File: rtl/gf_mix_column_pipe_if.sv
// Beat-level valid/ready bundle for the column mixer: input side with mode and last tag,
// output side with mixed data; master drives beats in, slave is the mixer.
interface gf_mix_column_pipe_if #(
  parameter int NUM_COLS = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic [1:0]                 in_mode;
  logic                       in_last;
  logic [32*NUM_COLS-1:0]     in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_last;
  logic [32*NUM_COLS-1:0]     out_data;

  modport master (
    output in_valid, in_mode, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_last, out_data
  );

  modport slave (
    input  in_valid, in_mode, in_last, in_data, out_ready,
    output in_ready, out_valid, out_last, out_data
  );
endinterface

// File: rtl/gf_mix_column_pipe.sv
// AES MixColumns / InvMixColumns / bypass per beat; latency PIPE_STAGES cycles, 1 beat/cycle.
// Stalls propagate back stage by stage when out_ready is low; output beat held stable.
module gf_mix_column_pipe #(
  parameter int NUM_COLS    = 4,
  parameter int PIPE_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gf_mix_column_pipe_if.slave  bus,
  output logic                 mode_err,
  output logic [CNT_W-1:0]     beat_cnt
);
  localparam int W  = 32 * NUM_COLS;
  localparam int NB = 4 * NUM_COLS;

  // One byte plus its doubling chain; every matrix constant is an XOR of these.
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
  } xbyte_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic xbyte_t expand(input logic [7:0] a);
    xbyte_t e;
    e.a  = a;
    e.x2 = xtime(a);
    e.x4 = xtime(e.x2);
    e.x8 = xtime(e.x4);
    return e;
  endfunction

  // b[0] is byte0 (column bits 31:24); modes 00 and 11 both pass the bytes through.
  function automatic logic [31:0] mix_col(input xbyte_t [3:0] b, input logic [1:0] mode);
    logic [3:0][7:0] rb;
    logic [1:0]      k;
    xbyte_t          p, q, s, t;
    rb = '0;
    for (int i = 0; i < 4; i++) begin
      k = 2'(i);
      p = b[k];
      q = b[k + 2'd1];
      s = b[k + 2'd2];
      t = b[k + 2'd3];
      case (mode)
        2'b01:   rb[2'd3 - k] = p.x2 ^ q.x2 ^ q.a ^ s.a ^ t.a;
        2'b10:   rb[2'd3 - k] = (p.x8 ^ p.x4 ^ p.x2) ^ (q.x8 ^ q.x2 ^ q.a)
                              ^ (s.x8 ^ s.x4 ^ s.a) ^ (t.x8 ^ t.a);
        default: rb[2'd3 - k] = p.a;
      endcase
    end
    return rb;
  endfunction

  xbyte_t [NB-1:0] in_x;
  xbyte_t [NB-1:0] mix_b;
  logic [1:0]      mix_mode;
  logic [W-1:0]    mixed;
  logic            src_vld;
  logic            src_last;
  logic            in_rdy;
  logic            out_open;
  logic            out_vld_q;
  logic            out_last_q;
  logic [W-1:0]    out_dat_q;

  for (genvar g = 0; g < NB; g++) begin : g_expand
    assign in_x[g] = expand(bus.in_data[32*(g/4) + 8*(3 - g%4) +: 8]);
  end

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_mix
    assign mixed[32*c +: 32] = mix_col(mix_b[4*c +: 4], mix_mode);
  end

  assign out_open = !out_vld_q || bus.out_ready;

  if (PIPE_STAGES == 2) begin : g_two
    logic            s1_vld;
    logic            s1_last;
    logic [1:0]      s1_mode;
    xbyte_t [NB-1:0] s1_b;

    // Stage 1 refills whenever it is empty or its beat moves on this cycle.
    assign in_rdy   = !s1_vld || out_open;
    assign src_vld  = s1_vld;
    assign src_last = s1_last;
    assign mix_b    = s1_b;
    assign mix_mode = s1_mode;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_vld  <= 1'b0;
        s1_last <= 1'b0;
        s1_mode <= 2'b00;
        s1_b    <= '0;
      end else if (in_rdy) begin
        s1_vld <= bus.in_valid;
        if (bus.in_valid) begin
          s1_last <= bus.in_last;
          s1_mode <= bus.in_mode;
          s1_b    <= in_x;
        end
      end
    end
  end else begin : g_one
    assign in_rdy   = out_open;
    assign src_vld  = bus.in_valid;
    assign src_last = bus.in_last;
    assign mix_b    = in_x;
    assign mix_mode = bus.in_mode;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_dat_q  <= '0;
    end else if (out_open) begin
      out_vld_q <= src_vld;
      if (src_vld) begin
        out_dat_q  <= mixed;
        out_last_q <= src_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      mode_err <= 1'b0;
    end else begin
      if (out_vld_q && bus.out_ready)
        beat_cnt <= beat_cnt + 1'b1;
      if (bus.in_valid && in_rdy && (bus.in_mode == 2'b11))
        mode_err <= 1'b1;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_dat_q;
endmodule

// File: tb/tb_gf_mix_column_pipe.sv
// Directed FIPS-197 vectors, random stream against a shift-and-add GF model, backpressure,
// sticky mode error, mid-stream reset and counter wrap.
module tb_gf_mix_column_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gf_mix_column_pipe_if #(.NUM_COLS(4)) b();
  gf_mix_column_pipe_if #(.NUM_COLS(1)) b1();
  logic        mode_err, mode_err1;
  logic [6:0]  beat_cnt;
  logic [15:0] beat_cnt1;

  gf_mix_column_pipe #(.NUM_COLS(4), .PIPE_STAGES(2), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b), .mode_err(mode_err), .beat_cnt(beat_cnt));
  gf_mix_column_pipe #(.NUM_COLS(1), .PIPE_STAGES(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .mode_err(mode_err1), .beat_cnt(beat_cnt1));

  typedef struct packed { logic [127:0] d; logic [1:0] m; logic l; } beat_t;
  typedef struct packed { logic [127:0] d; logic l; } want_t;

  int           n_vec = 0;
  int           n_err = 0;
  int           n_out = 0;
  int           busy_cnt = 0;
  beat_t        pend[$];
  want_t        want_q[$];
  logic         hold_pend = 1'b0;
  logic [127:0] held_d;
  logic         held_l;
  logic         want_err = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] m);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = m;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] ref_col(input logic [31:0] c, input logic [1:0] m);
    logic [7:0]  cf [4];
    logic [7:0]  a  [4];
    logic [31:0] res;
    logic [7:0]  acc;
    if (m == 2'b01) begin
      cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
    end else if (m == 2'b10) begin
      cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
    end else begin
      return c;
    end
    for (int k = 0; k < 4; k++) a[k] = c[31-8*k -: 8];
    res = '0;
    for (int r = 0; r < 4; r++) begin
      acc = 8'h00;
      for (int k = 0; k < 4; k++) acc = acc ^ gmul(a[k], cf[(k - r + 4) % 4]);
      res[31-8*r -: 8] = acc;
    end
    return res;
  endfunction

  function automatic logic [127:0] ref_beat(input logic [127:0] d, input logic [1:0] m);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[32*c +: 32] = ref_col(d[32*c +: 32], m);
    return r;
  endfunction

  // One clock of the streaming engine: present head of pend, score handshakes, check holds.
  task automatic cycle(input logic ordy);
    want_t e;
    b.out_ready = ordy;
    if (pend.size() > 0) begin
      b.in_valid = 1'b1;
      b.in_data  = pend[0].d;
      b.in_mode  = pend[0].m;
      b.in_last  = pend[0].l;
    end else begin
      b.in_valid = 1'b0;
      b.in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      b.in_mode  = 2'($urandom_range(0, 3));
      b.in_last  = 1'($urandom_range(0, 1));
    end
    #1;
    if (hold_pend) begin
      chk("hold_vld", 128'(b.out_valid), 128'd1);
      chk("hold_dat", b.out_data, held_d);
      chk("hold_last", 128'(b.out_last), 128'(held_l));
    end
    if (b.in_valid && b.in_ready) begin
      e.d = ref_beat(pend[0].d, pend[0].m);
      e.l = pend[0].l;
      want_q.push_back(e);
      if (pend[0].m == 2'b11) want_err = 1'b1;
      void'(pend.pop_front());
    end
    if (!b.in_ready) busy_cnt++;
    if (b.out_valid && b.out_ready) begin
      chk("out_expected", 128'(want_q.size() != 0), 128'd1);
      if (want_q.size() != 0) begin
        e = want_q.pop_front();
        chk("out_dat", b.out_data, e.d);
        chk("out_last", 128'(b.out_last), 128'(e.l));
      end
      n_out++;
    end
    hold_pend = b.out_valid && !b.out_ready;
    held_d    = b.out_data;
    held_l    = b.out_last;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((pend.size() > 0 || want_q.size() > 0) && n < 400) begin
      cycle(1'b1);
      n++;
    end
    chk(tag, 128'(pend.size() + want_q.size()), 128'd0);
  endtask

  task automatic push_rand(input int n);
    beat_t bt;
    for (int i = 0; i < n; i++) begin
      bt.d = {$urandom(), $urandom(), $urandom(), $urandom()};
      bt.m = 2'($urandom_range(0, 3));
      bt.l = 1'(i & 1);
      pend.push_back(bt);
    end
  endtask

  task automatic xact(input logic [1:0] m, input logic [127:0] d, input logic l,
                      output logic [127:0] od, output logic ol, output int lat);
    b.out_ready = 1'b1;
    b.in_valid  = 1'b1;
    b.in_mode   = m;
    b.in_data   = d;
    b.in_last   = l;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      b.in_valid = 1'b0;
    end while (!b.out_valid && lat < 10);
    od = b.out_data;
    ol = b.out_last;
  endtask

  task automatic xact1(input logic [1:0] m, input logic [31:0] d,
                       output logic [31:0] od, output int lat);
    b1.out_ready = 1'b1;
    b1.in_valid  = 1'b1;
    b1.in_mode   = m;
    b1.in_data   = d;
    b1.in_last   = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      b1.in_valid = 1'b0;
    end while (!b1.out_valid && lat < 10);
    od = b1.out_data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] od;
    logic [31:0]  od1;
    logic         ol;
    int           lat, cyc, stale;

    b.in_valid = 1'b0;  b.in_mode = 2'b00;  b.in_last = 1'b0;  b.in_data = '0;  b.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_mode = 2'b00; b1.in_last = 1'b0; b1.in_data = '0; b1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(b.out_valid), 128'd0);
    chk("rst_out_data", b.out_data, 128'd0);
    chk("rst_out_last", 128'(b.out_last), 128'd0);
    chk("rst_beat_cnt", 128'(beat_cnt), 128'd0);
    chk("rst_mode_err", 128'(mode_err), 128'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 128'(b.in_ready), 128'd1);
    chk("rst_in_ready1", 128'(b1.in_ready), 128'd1);

    // Forward MixColumns: FIPS-197 columns, single-byte column, and a fixed point.
    xact(2'b01, {32'hc6c6c6c6, 32'h01000000, 32'hf20a225c, 32'hdb135345}, 1'b0, od, ol, lat);
    chk("fwd_dat", od, {32'hc6c6c6c6, 32'h02010103, 32'h9fdc589d, 32'h8e4da1bc});
    chk("fwd_last", 128'(ol), 128'd0);
    chk("fwd_lat", 128'(lat), 128'd2);

    xact(2'b10, {32'h9fdc589d, 32'h00000100, 32'h01000000, 32'h8e4da1bc}, 1'b1, od, ol, lat);
    chk("inv_dat", od, {32'hf20a225c, 32'h0d0b0e09, 32'h0e090d0b, 32'hdb135345});
    chk("inv_last", 128'(ol), 128'd1);
    chk("inv_lat", 128'(lat), 128'd2);

    xact(2'b00, {32'h01234567, 32'h89abcdef, 32'hdeadbeef, 32'h00ff00ff}, 1'b0, od, ol, lat);
    chk("byp_dat", od, {32'h01234567, 32'h89abcdef, 32'hdeadbeef, 32'h00ff00ff});
    chk("byp_lat", 128'(lat), 128'd2);
    chk("byp_no_err", 128'(mode_err), 128'd0);

    xact(2'b11, {4{32'hc6c6c6c6}}, 1'b0, od, ol, lat);
    chk("m11_dat", od, {4{32'hc6c6c6c6}});
    chk("m11_err", 128'(mode_err), 128'd1);
    xact(2'b00, {4{32'h11223344}}, 1'b0, od, ol, lat);
    chk("m11_err_sticky", 128'(mode_err), 128'd1);
    @(posedge clk);
    #1;
    chk("cnt_after_5", 128'(beat_cnt), 128'd5);

    xact1(2'b01, 32'hdb135345, od1, lat);
    chk("one_fwd_dat", 128'(od1), 128'(32'h8e4da1bc));
    chk("one_fwd_lat", 128'(lat), 128'd1);
    xact1(2'b10, 32'h8e4da1bc, od1, lat);
    chk("one_inv_dat", 128'(od1), 128'(32'hdb135345));
    chk("one_inv_lat", 128'(lat), 128'd1);

    rst_n = 1'b0;
    #1;
    chk("rst2_mode_err", 128'(mode_err), 128'd0);
    chk("rst2_beat_cnt", 128'(beat_cnt), 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 64-beat random stream at full rate.
    push_rand(64);
    n_out = 0;
    busy_cnt = 0;
    cyc = 0;
    while (n_out < 64 && cyc < 300) begin
      cycle(1'b1);
      cyc++;
    end
    chk("stream_cycles", 128'(cyc), 128'd66);
    chk("stream_busy", 128'(busy_cnt), 128'd0);
    chk("stream_cnt", 128'(beat_cnt), 128'd64);
    chk("stream_err", 128'(mode_err), 128'(want_err));

    // Backpressure: out_ready low for 5 cycles with the pipe full.
    push_rand(10);
    busy_cnt = 0;
    repeat (3) cycle(1'b1);
    repeat (5) cycle(1'b0);
    drain("bp_drain");
    chk("bp_busy_cycles", 128'(busy_cnt), 128'd5);
    chk("bp_cnt", 128'(beat_cnt), 128'd74);

    // Reset with two beats in flight.
    push_rand(2);
    cycle(1'b1);
    cycle(1'b1);
    chk("pre_rst_vld", 128'(b.out_valid), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(b.out_valid), 128'd0);
    chk("midrst_beat_cnt", 128'(beat_cnt), 128'd0);
    pend.delete();
    want_q.delete();
    hold_pend = 1'b0;
    want_err  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stale = 0;
    repeat (4) begin
      cycle(1'b1);
      stale += int'(b.out_valid);
    end
    chk("no_stale", 128'(stale), 128'd0);

    // Counter wrap for a 7-bit counter.
    push_rand(127);
    drain("wrap_drain");
    chk("cnt_all_ones", 128'(beat_cnt), 128'd127);
    chk("wrap_err", 128'(mode_err), 128'(want_err));
    push_rand(1);
    drain("wrap_drain2");
    chk("cnt_wrap", 128'(beat_cnt), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
